// File: rtl/cpu_regfile.sv
// General-purpose register file for the 8-bit CPU: two registered read ports, a write port,
// a tri-state bus port for loads/stores, write-through bypass and a pending-load scoreboard.
module cpu_regfile #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_a_en,
    input  logic [ADDR_W-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic              rd_b_en,
    input  logic [ADDR_W-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              stall_a,
    output logic              stall_b,
    input  logic [ADDR_W-1:0] bus_sel,
    input  logic              bus_oe_req,
    input  logic              bus_ld,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DEPTH-1:0]  pend,
    output logic              wr_conflict
);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;
    logic              bus_oe_q;
    logic [DATA_W-1:0] bus_out_q;
    logic [DATA_W-1:0] bus_din;
    logic              ld_eff;
    logic              wr_commit;
    logic              ld_commit;
    logic              conflict_d;
    logic              same_addr;
    logic [DATA_W-1:0] byp_a;
    logic [DATA_W-1:0] byp_b;
    logic [DATA_W-1:0] byp_bus;
    logic              hit_a;
    logic              hit_b;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Write port beats a same-cycle bus load, which beats stored state.
    function automatic logic [DATA_W-1:0] bypass(input logic [ADDR_W-1:0] a,
                                                 input logic              w_en,
                                                 input logic [ADDR_W-1:0] w_addr,
                                                 input logic [DATA_W-1:0] w_data,
                                                 input logic              l_eff,
                                                 input logic [ADDR_W-1:0] l_addr,
                                                 input logic [DATA_W-1:0] l_data,
                                                 input logic [DATA_W-1:0] stored);
        if (is_zero(a))
            return '0;
        else if (w_en && (w_addr == a))
            return w_data;
        else if (l_eff && (l_addr == a))
            return l_data;
        else
            return stored;
    endfunction

    assign bus_din  = data_bus;
    assign data_bus = bus_oe_q ? bus_out_q : {DATA_W{1'bz}};

    assign ld_eff     = bus_ld & ~bus_oe_req;
    assign same_addr  = wr_en & ld_eff & (wr_addr == bus_sel);
    assign wr_commit  = wr_en & ~is_zero(wr_addr);
    assign ld_commit  = ld_eff & ~same_addr & ~is_zero(bus_sel);
    // Writes to a hard-wired zero register vanish without flagging a conflict.
    assign conflict_d = (bus_ld & bus_oe_req) | (same_addr & ~is_zero(bus_sel));

    assign byp_a   = bypass(rd_a_addr, wr_en, wr_addr, wr_data, ld_eff, bus_sel, bus_din, regs[rd_a_addr]);
    assign byp_b   = bypass(rd_b_addr, wr_en, wr_addr, wr_data, ld_eff, bus_sel, bus_din, regs[rd_b_addr]);
    assign byp_bus = bypass(bus_sel, wr_en, wr_addr, wr_data, ld_eff, bus_sel, bus_din, regs[bus_sel]);

    assign hit_a   = (wr_en & (wr_addr == rd_a_addr)) | (ld_eff & (bus_sel == rd_a_addr));
    assign hit_b   = (wr_en & (wr_addr == rd_b_addr)) | (ld_eff & (bus_sel == rd_b_addr));
    assign stall_a = rd_a_en & pend_q[rd_a_addr] & ~hit_a;
    assign stall_b = rd_b_en & pend_q[rd_b_addr] & ~hit_b;
    assign pend    = pend_q;

    // A reservation landing on the same cycle as a clearing write keeps the bit set.
    always_comb begin
        pend_d = pend_q;
        if (wr_commit)
            pend_d[wr_addr] = 1'b0;
        if (ld_commit)
            pend_d[bus_sel] = 1'b0;
        if (rsv_en && !is_zero(rsv_addr))
            pend_d[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            if (wr_commit)
                regs[wr_addr] <= wr_data;
            if (ld_commit)
                regs[bus_sel] <= bus_din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_a_data   <= '0;
            rd_b_data   <= '0;
            pend_q      <= '0;
            bus_oe_q    <= 1'b0;
            bus_out_q   <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (rd_a_en && !stall_a)
                rd_a_data <= byp_a;
            if (rd_b_en && !stall_b)
                rd_b_data <= byp_b;
            pend_q      <= pend_d;
            bus_oe_q    <= bus_oe_req;
            if (bus_oe_req)
                bus_out_q <= byp_bus;
            wr_conflict <= conflict_d;
        end
    end

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed bench for cpu_regfile (ZERO_REG=1): reads, bypass, scoreboard, conflicts, bus drive.
module tb_cpu_regfile;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_a_en;
    logic [2:0] rd_a_addr;
    logic [7:0] rd_a_data;
    logic       rd_b_en;
    logic [2:0] rd_b_addr;
    logic [7:0] rd_b_data;
    logic       stall_a;
    logic       stall_b;
    logic [2:0] bus_sel;
    logic       bus_oe_req;
    logic       bus_ld;
    wire  [7:0] data_bus;
    logic       rsv_en;
    logic [2:0] rsv_addr;
    logic [7:0] pend;
    logic       wr_conflict;
    logic       tb_oe;
    logic [7:0] tb_drv;

    int total = 0;
    int bad   = 0;

    assign data_bus = tb_oe ? tb_drv : 8'bz;

    cpu_regfile #(.DATA_W(8), .DEPTH(8), .ADDR_W(3), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_a_en(rd_a_en), .rd_a_addr(rd_a_addr), .rd_a_data(rd_a_data),
        .rd_b_en(rd_b_en), .rd_b_addr(rd_b_addr), .rd_b_data(rd_b_data),
        .stall_a(stall_a), .stall_b(stall_b),
        .bus_sel(bus_sel), .bus_oe_req(bus_oe_req), .bus_ld(bus_ld),
        .data_bus(data_bus),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .pend(pend), .wr_conflict(wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        rd_a_en = 0; rd_a_addr = 0; rd_b_en = 0; rd_b_addr = 0;
        bus_sel = 0; bus_oe_req = 0; bus_ld = 0;
        rsv_en = 0; rsv_addr = 0; tb_oe = 0; tb_drv = 0;
        #12;
        chk("rst_rd_a", rd_a_data, 8'h00);
        chk("rst_rd_b", rd_b_data, 8'h00);
        chk("rst_pend", pend, 8'h00);
        chk("rst_conflict", wr_conflict, 1'b0);
        reset = 1'b0;

        // basic write then read, then asynchronous reset mid-read
        wr_en = 1; wr_addr = 3; wr_data = 8'hA5;
        tick();
        wr_en = 0; rd_a_en = 1; rd_a_addr = 3;
        tick();
        chk("read_r3", rd_a_data, 8'hA5);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_rd_a", rd_a_data, 8'h00);
        reset = 1'b0;
        tick();
        chk("r3_cleared_by_rst", rd_a_data, 8'h00);
        rd_a_en = 0;

        // same-cycle bypass to both ports
        wr_en = 1; wr_addr = 5; wr_data = 8'h3C;
        rd_a_en = 1; rd_a_addr = 5; rd_b_en = 1; rd_b_addr = 5;
        tick();
        chk("bypass_a", rd_a_data, 8'h3C);
        chk("bypass_b", rd_b_data, 8'h3C);
        wr_en = 0; rd_a_en = 0; rd_b_en = 0;

        // scoreboard: reserve R2, stalled read holds, bus load clears and bypasses
        rsv_en = 1; rsv_addr = 2;
        tick();
        rsv_en = 0;
        chk("pend_r2", pend, 8'h04);
        rd_a_en = 1; rd_a_addr = 2;
        #1;
        chk("stall_a_set", stall_a, 1'b1);
        tick();
        chk("stalled_hold", rd_a_data, 8'h3C);
        tb_oe = 1; tb_drv = 8'h77; bus_ld = 1; bus_sel = 2;
        #1;
        chk("stall_a_cleared_by_load", stall_a, 1'b0);
        tick();
        chk("load_bypass_a", rd_a_data, 8'h77);
        chk("pend_r2_clear", pend, 8'h00);
        tb_oe = 0; bus_ld = 0; rd_a_en = 0;

        // set/clear race on R4: data written, bit stays pending
        rsv_en = 1; rsv_addr = 4; wr_en = 1; wr_addr = 4; wr_data = 8'h44;
        tick();
        rsv_en = 0; wr_en = 0;
        chk("race_pend", pend, 8'h10);
        rd_b_en = 1; rd_b_addr = 4;
        bus_oe_req = 1; bus_sel = 4;
        #1;
        chk("stall_b_r4", stall_b, 1'b1);
        tick();
        chk("race_r4_data", data_bus, 8'h44);
        rd_b_en = 0; bus_oe_req = 0;
        tick();

        // same-address write-port vs bus-load conflict
        wr_en = 1; wr_addr = 1; wr_data = 8'h11;
        bus_ld = 1; bus_sel = 1; tb_oe = 1; tb_drv = 8'h22;
        tick();
        wr_en = 0; bus_ld = 0; tb_oe = 0;
        chk("conflict_pulse", wr_conflict, 1'b1);
        rd_a_en = 1; rd_a_addr = 1;
        tick();
        chk("conflict_pulse_end", wr_conflict, 1'b0);
        chk("conflict_r1", rd_a_data, 8'h11);
        rd_a_en = 0;

        // illegal bus_ld with bus_oe_req: load dropped, register driven instead
        wr_en = 1; wr_addr = 7; wr_data = 8'h70;
        tick();
        wr_en = 0;
        bus_ld = 1; bus_oe_req = 1; bus_sel = 7; tb_oe = 1; tb_drv = 8'h99;
        tick();
        bus_ld = 0; bus_oe_req = 0; tb_oe = 0;
        chk("illegal_pulse", wr_conflict, 1'b1);
        #1;
        chk("illegal_drive", data_bus, 8'h70);
        rd_a_en = 1; rd_a_addr = 7;
        tick();
        chk("illegal_pulse_end", wr_conflict, 1'b0);
        chk("illegal_r7_kept", rd_a_data, 8'h70);
        rd_a_en = 0;

        // bus drive and release timing
        wr_en = 1; wr_addr = 6; wr_data = 8'h5A;
        tick();
        wr_en = 0; bus_oe_req = 1; bus_sel = 6;
        tick();
        chk("drive_1", data_bus, 8'h5A);
        tick();
        chk("drive_2", data_bus, 8'h5A);
        bus_oe_req = 0;
        #1;
        chk("drive_holds_before_edge", data_bus, 8'h5A);
        tick();
        tb_oe = 1; tb_drv = 8'h0F;
        #1;
        chk("released_bus", data_bus, 8'h0F);
        tb_oe = 0;

        // hard-wired zero register
        wr_en = 1; wr_addr = 0; wr_data = 8'hFF;
        rd_a_en = 1; rd_a_addr = 0;
        tick();
        wr_en = 0;
        chk("r0_bypass_zero", rd_a_data, 8'h00);
        chk("r0_no_conflict", wr_conflict, 1'b0);
        rsv_en = 1; rsv_addr = 0;
        tick();
        rsv_en = 0;
        chk("r0_read_zero", rd_a_data, 8'h00);
        chk("r0_never_pending", pend, 8'h10);
        rd_a_en = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
